frame_block_scheduler: RTL and testbench

- Owns allocation of the SDRAM frame-buffer blocks shared by the camera write path and the HDMI read path.
- Hands the writer a free block at each camera frame start.
- Publishes the newest completed block and hands it to the reader at each display frame start.
- Sits in the sys_clk domain between the frame write/read engines and the Avalon bus arbiter. Replaces the fixed occupy_block_num wiring.

---
 rtl/frame_sched_pkg.sv | 21 ++
 rtl/free_block_pick.sv | 29 ++
 rtl/frame_block_scheduler.sv | 142 ++++++++++++++
 tb/tb_frame_block_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame-buffer block scheduler.
// Block indices, ownership slots and a slot-occupancy helper.
package frame_sched_pkg;

    localparam int unsigned BLOCK_W             = 2;
    localparam int unsigned MAX_BLOCKS          = 1 << BLOCK_W;
    localparam int unsigned DEFAULT_BLOCK_WORDS = 32'h0010_0000;

    typedef logic [BLOCK_W-1:0] block_idx_t;

    typedef struct packed {
        block_idx_t idx;
        logic       valid;
    } block_slot_t;

    // True when the slot currently owns block idx.
    function automatic logic slot_holds(input block_slot_t slot, input block_idx_t idx);
        return slot.valid && (slot.idx == idx);
    endfunction

endpackage

// File: rtl/free_block_pick.sv
// Combinational priority encoder: lowest block index owned by none of the three slots.
module free_block_pick
    import frame_sched_pkg::*;
#(
    parameter int unsigned BLOCK_NUM = 3
) (
    input  block_slot_t wr_slot_i,
    input  block_slot_t rd_slot_i,
    input  block_slot_t latest_slot_i,
    output block_idx_t  free_idx_c_o
);

    logic found;

    always_comb begin
        free_idx_c_o = '0;
        found        = 1'b0;
        for (int unsigned i = 0; i < MAX_BLOCKS; i++) begin
            if (!found && (i < BLOCK_NUM) &&
                !slot_holds(wr_slot_i, block_idx_t'(i)) &&
                !slot_holds(rd_slot_i, block_idx_t'(i)) &&
                !slot_holds(latest_slot_i, block_idx_t'(i))) begin
                free_idx_c_o = block_idx_t'(i);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_block_scheduler.sv
// Allocates SDRAM frame blocks between the camera writer and the HDMI reader.
// Optional screenshot hold enabled by defining FRAME_SCHED_FREEZE_EN.
module frame_block_scheduler
    import frame_sched_pkg::*;
#(
    parameter int unsigned           BLOCK_NUM   = 3,
    parameter int unsigned           ADDR_W      = 24,
    parameter logic [ADDR_W-1:0]     BLOCK_WORDS = ADDR_W'(DEFAULT_BLOCK_WORDS),
    parameter int unsigned           CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rest_n,
    input  logic                wr_frame_start,
    input  logic                wr_frame_done,
    output logic [BLOCK_W-1:0]  wr_block,
    output logic                wr_block_valid,
    output logic [ADDR_W-1:0]   wr_base_addr,
    input  logic                rd_frame_start,
    output logic [BLOCK_W-1:0]  rd_block,
    output logic                rd_block_valid,
    output logic [ADDR_W-1:0]   rd_base_addr,
    output logic                rd_new_frame,
    input  logic                freeze,
    output logic [CNT_W-1:0]    drop_cnt
);

    block_idx_t        wr_idx_q, wr_idx_d;
    logic              wr_valid_q, wr_valid_d;
    block_idx_t        rd_idx_q, rd_idx_s;
    logic              rd_valid_q, rd_valid_s;
    block_idx_t        latest_idx_q, latest_idx_s;
    logic              latest_valid_q, latest_valid_s;
    logic              rd_new_q, rd_new_s;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [ADDR_W-1:0] wr_base_q, rd_base_q;
    logic              wr_valid_s;
    logic              freeze_hold;
    block_slot_t       wr_slot, rd_slot, latest_slot;
    block_idx_t        free_idx;

`ifdef FRAME_SCHED_FREEZE_EN
    assign freeze_hold = freeze;
`else
    logic unused_freeze;
    assign unused_freeze = freeze;
    assign freeze_hold   = 1'b0;
`endif

    function automatic logic [ADDR_W-1:0] base_of(input block_idx_t idx);
        return ADDR_W'(idx) * BLOCK_WORDS;
    endfunction

    // First stage: writer completion, then reader hand-off.
    always_comb begin
        wr_valid_s     = wr_valid_q;
        latest_idx_s   = latest_idx_q;
        latest_valid_s = latest_valid_q;
        rd_idx_s       = rd_idx_q;
        rd_valid_s     = rd_valid_q;
        rd_new_s       = rd_new_q;
        if (wr_frame_done && wr_valid_q) begin
            latest_idx_s   = wr_idx_q;
            latest_valid_s = 1'b1;
            wr_valid_s     = 1'b0;
        end
        if (rd_frame_start) begin
            rd_new_s = 1'b0;
            if (latest_valid_s && !freeze_hold) begin
                rd_idx_s       = latest_idx_s;
                rd_valid_s     = 1'b1;
                latest_valid_s = 1'b0;
                rd_new_s       = 1'b1;
            end
        end
    end

    // A starting writer releases whatever it held before a new block is chosen.
    always_comb begin
        wr_slot     = '{idx: wr_idx_q, valid: wr_valid_s && !wr_frame_start};
        rd_slot     = '{idx: rd_idx_s, valid: rd_valid_s};
        latest_slot = '{idx: latest_idx_s, valid: latest_valid_s};
    end

    free_block_pick #(
        .BLOCK_NUM (BLOCK_NUM)
    ) u_pick (
        .wr_slot_i     (wr_slot),
        .rd_slot_i     (rd_slot),
        .latest_slot_i (latest_slot),
        .free_idx_c_o  (free_idx)
    );

    // Second stage: writer grant and abandoned-frame accounting.
    always_comb begin
        wr_idx_d   = wr_idx_q;
        wr_valid_d = wr_valid_s;
        drop_d     = drop_q;
        if (wr_frame_start) begin
            if (wr_valid_s && (drop_q != '1)) begin
                drop_d = drop_q + CNT_W'(1);
            end
            wr_idx_d   = free_idx;
            wr_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            wr_idx_q       <= '0;
            wr_valid_q     <= 1'b0;
            rd_idx_q       <= '0;
            rd_valid_q     <= 1'b0;
            latest_idx_q   <= '0;
            latest_valid_q <= 1'b0;
            rd_new_q       <= 1'b0;
            drop_q         <= '0;
            wr_base_q      <= '0;
            rd_base_q      <= '0;
        end else begin
            wr_idx_q       <= wr_idx_d;
            wr_valid_q     <= wr_valid_d;
            rd_idx_q       <= rd_idx_s;
            rd_valid_q     <= rd_valid_s;
            latest_idx_q   <= latest_idx_s;
            latest_valid_q <= latest_valid_s;
            rd_new_q       <= rd_new_s;
            drop_q         <= drop_d;
            wr_base_q      <= base_of(wr_idx_d);
            rd_base_q      <= base_of(rd_idx_s);
        end
    end

    assign wr_block       = wr_idx_q;
    assign wr_block_valid = wr_valid_q;
    assign wr_base_addr   = wr_base_q;
    assign rd_block       = rd_idx_q;
    assign rd_block_valid = rd_valid_q;
    assign rd_base_addr   = rd_base_q;
    assign rd_new_frame   = rd_new_q;
    assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_frame_block_scheduler.sv
// Self-checking bench for frame_block_scheduler: vector table, scoreboard queue, corner sequences.
module tb_frame_block_scheduler;

    typedef struct packed {
        logic [1:0]  wr_b;
        logic        wr_v;
        logic [23:0] wr_a;
        logic [1:0]  rd_b;
        logic        rd_v;
        logic [23:0] rd_a;
        logic        rd_n;
        logic [15:0] drop;
    } exp_t;

    typedef struct {
        logic d;
        logic r;
        logic w;
        exp_t e;
    } vec_t;

    logic        clk;
    logic        rest_n;
    logic        wr_frame_start;
    logic        wr_frame_done;
    logic [1:0]  wr_block;
    logic        wr_block_valid;
    logic [23:0] wr_base_addr;
    logic        rd_frame_start;
    logic [1:0]  rd_block;
    logic        rd_block_valid;
    logic [23:0] rd_base_addr;
    logic        rd_new_frame;
    logic        freeze;
    logic [15:0] drop_cnt;

    int   checks;
    int   errors;
    exp_t sb_q[$];
    vec_t tbl[16];

    frame_block_scheduler dut (
        .clk            (clk),
        .rest_n         (rest_n),
        .wr_frame_start (wr_frame_start),
        .wr_frame_done  (wr_frame_done),
        .wr_block       (wr_block),
        .wr_block_valid (wr_block_valid),
        .wr_base_addr   (wr_base_addr),
        .rd_frame_start (rd_frame_start),
        .rd_block       (rd_block),
        .rd_block_valid (rd_block_valid),
        .rd_base_addr   (rd_base_addr),
        .rd_new_frame   (rd_new_frame),
        .freeze         (freeze),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [1:0] wb, input logic wv, input logic [1:0] rb,
                                input logic rv, input logic rn, input logic [15:0] dc);
        exp_t e;
        e.wr_b = wb;
        e.wr_v = wv;
        e.wr_a = 24'(wb) * 24'h10_0000;
        e.rd_b = rb;
        e.rd_v = rv;
        e.rd_a = 24'(rb) * 24'h10_0000;
        e.rd_n = rn;
        e.drop = dc;
        return e;
    endfunction

    function automatic exp_t sample();
        return {wr_block, wr_block_valid, wr_base_addr, rd_block, rd_block_valid,
                rd_base_addr, rd_new_frame, drop_cnt};
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got wr=%0d/%0b/%h rd=%0d/%0b/%h new=%0b drop=%h want wr=%0d/%0b/%h rd=%0d/%0b/%h new=%0b drop=%h",
                     name, got.wr_b, got.wr_v, got.wr_a, got.rd_b, got.rd_v, got.rd_a, got.rd_n, got.drop,
                     want.wr_b, want.wr_v, want.wr_a, want.rd_b, want.rd_v, want.rd_a, want.rd_n, want.drop);
        end
    endtask

    // Drive one cycle of pulses, queue the expectation, compare once the edge has landed.
    task automatic step(input logic d, input logic r, input logic w, input logic f,
                        input exp_t e, input string name);
        exp_t want;
        @(negedge clk);
        wr_frame_done  = d;
        rd_frame_start = r;
        wr_frame_start = w;
        freeze         = f;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        wr_frame_done  = 1'b0;
        rd_frame_start = 1'b0;
        wr_frame_start = 1'b0;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            want = sb_q.pop_front();
            check(name, sample(), want);
        end
    endtask

    initial begin
        logic [15:0] exp_drop;
        logic [1:0]  exp_w;
        logic        exp_new;

        checks = 0;
        errors = 0;
        rest_n = 1'b0;
        wr_frame_start = 1'b0;
        wr_frame_done  = 1'b0;
        rd_frame_start = 1'b0;
        freeze         = 1'b0;

        //           done  rd    wr    wb wv rb rv new drop
        tbl[0]  = '{1'b0, 1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0)};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0)};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, mk(1, 1, 0, 0, 0, 0)};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, mk(1, 1, 0, 1, 1, 0)};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 0)};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, mk(2, 1, 0, 1, 1, 0)};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, mk(1, 1, 0, 1, 1, 0)};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, mk(1, 1, 2, 1, 1, 0)};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, mk(1, 0, 2, 1, 1, 0)};
        tbl[10] = '{1'b0, 1'b0, 1'b1, mk(0, 1, 2, 1, 1, 0)};
        tbl[11] = '{1'b0, 1'b0, 1'b1, mk(0, 1, 2, 1, 1, 1)};
        tbl[12] = '{1'b1, 1'b1, 1'b0, mk(0, 0, 0, 1, 1, 1)};
        tbl[13] = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 1, 0, 1)};
        tbl[14] = '{1'b0, 1'b0, 1'b1, mk(1, 1, 0, 1, 0, 1)};
        tbl[15] = '{1'b0, 1'b0, 1'b1, mk(1, 1, 0, 1, 0, 2)};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", sample(), mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rest_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].d, tbl[i].r, tbl[i].w, 1'b0, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Back-to-back abandoned writes drive the drop counter into saturation.
        exp_drop = 16'd2;
        for (int i = 0; i < 70000; i++) begin
            if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
            step(1'b0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 1, 0, exp_drop), "drop_sat");
        end
        check("drop_sat_final", sample(), mk(1, 1, 0, 1, 0, 16'hFFFF));

        // Reset while both sides own blocks drops all ownership.
        @(negedge clk);
        rest_n = 1'b0;
        #1;
        check("mid_reset", sample(), mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rest_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0), "restart_wr");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), "restart_done");
        step(1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 0), "restart_rd");

`ifdef FRAME_SCHED_FREEZE_EN
        exp_new = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_w = (k % 2 == 0) ? 2'd1 : 2'd2;
            step(1'b0, 1'b0, 1'b1, 1'b1, mk(exp_w, 1, 0, 1, exp_new, 0), $sformatf("frz_wr%0d", k));
            step(1'b1, 1'b0, 1'b0, 1'b1, mk(exp_w, 0, 0, 1, exp_new, 0), $sformatf("frz_done%0d", k));
            exp_new = 1'b0;
            step(1'b0, 1'b1, 1'b0, 1'b1, mk(exp_w, 0, 0, 1, 0, 0), $sformatf("frz_rd%0d", k));
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, mk(1, 0, 1, 1, 1, 0), "frz_release");
`else
        exp_w   = 2'd1;
        exp_new = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b1, mk(exp_w, 1, 0, 1, exp_new, 0), "nofrz_wr");
        step(1'b1, 1'b0, 1'b0, 1'b1, mk(exp_w, 0, 0, 1, exp_new, 0), "nofrz_done");
        step(1'b0, 1'b1, 1'b0, 1'b1, mk(exp_w, 0, 1, 1, exp_new, 0), "nofrz_rd");
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(0, 1, 1, 1, 1, 0), "nofrz_wr2");
`endif

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
